// File: rtl/ps2_scancode_rx_if.sv
// PS/2 line inputs and decoded receive outputs of ps2_scancode_rx.
// master: the receiver; slave: the consumer that owns the PS/2 lines in simulation.
interface ps2_scancode_rx_if;
    logic       PS2_CLK;
    logic       PS2_DAT;
    logic [7:0] received_data;
    logic       received_data_en;
    logic       parity_error;
    logic       frame_error;
    logic [7:0] key_code;
    logic       key_extended;
    logic       key_release;
    logic       key_valid;

    modport master (
        input  PS2_CLK, PS2_DAT,
        output received_data, received_data_en, parity_error, frame_error,
        output key_code, key_extended, key_release, key_valid
    );

    modport slave (
        output PS2_CLK, PS2_DAT,
        input  received_data, received_data_en, parity_error, frame_error,
        input  key_code, key_extended, key_release, key_valid
    );
endinterface

// File: rtl/ps2_scancode_rx.sv
// Device-to-host PS/2 receiver: synchronise/filter the lines, deserialise 11-bit
// frames with odd parity, and fold E0/F0 prefixes into single key events.
module ps2_scancode_rx #(
    parameter int unsigned CLK_FILTER = 4,
    parameter int unsigned TIMEOUT    = 50000
) (
    input  logic               CLOCK_50,
    input  logic               resetn,
    ps2_scancode_rx_if.master  ps2
);
    localparam int unsigned FW = $clog2(CLK_FILTER + 1);
    localparam int unsigned TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [1:0]    clk_sync, dat_sync;
    logic          filt_clk, fall;
    logic [FW-1:0] filt_cnt;
    logic          rx_bit;

    state_t        state, state_nxt;
    logic [7:0]    shift, shift_nxt;
    logic [2:0]    bit_cnt, bit_cnt_nxt;
    logic          par_bit, par_nxt;
    logic [TW-1:0] tmo_cnt, tmo_nxt;
    logic          timed_out;

    logic [7:0]    rx_data, rx_data_nxt;
    logic          rx_en, rx_en_nxt;
    logic          perr, perr_nxt;
    logic          ferr, ferr_nxt;

    logic          pend_ext, pend_rel;
    logic [7:0]    key_code_q;
    logic          key_ext_q, key_rel_q, key_valid_q;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            clk_sync <= '1;
            dat_sync <= '1;
        end else begin
            clk_sync <= {clk_sync[0], ps2.PS2_CLK};
            dat_sync <= {dat_sync[0], ps2.PS2_DAT};
        end
    end

    // fall is raised in the same cycle the filtered clock drops to 0
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            filt_clk <= 1'b1;
            filt_cnt <= '0;
            fall     <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (clk_sync[1] != filt_clk) begin
                if (filt_cnt == FW'(CLK_FILTER - 1)) begin
                    filt_clk <= clk_sync[1];
                    filt_cnt <= '0;
                    fall     <= filt_clk;
                end else begin
                    filt_cnt <= filt_cnt + 1'b1;
                end
            end else begin
                filt_cnt <= '0;
            end
        end
    end

    assign rx_bit    = dat_sync[1];
    assign timed_out = (state != IDLE) && !fall && (tmo_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (timed_out) begin
            state_nxt = IDLE;
        end else if (fall) begin
            unique case (state)
                IDLE:    if (!rx_bit) state_nxt = DATA;
                DATA:    if (bit_cnt == 3'd7) state_nxt = PARITY;
                PARITY:  state_nxt = STOP;
                STOP:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        shift_nxt   = shift;
        bit_cnt_nxt = bit_cnt;
        par_nxt     = par_bit;
        rx_data_nxt = rx_data;
        rx_en_nxt   = 1'b0;
        perr_nxt    = 1'b0;
        ferr_nxt    = 1'b0;
        tmo_nxt     = (fall || timed_out || state == IDLE) ? '0 : tmo_cnt + 1'b1;
        if (timed_out) begin
            ferr_nxt    = 1'b1;
            shift_nxt   = '0;
            bit_cnt_nxt = '0;
        end else if (fall) begin
            unique case (state)
                IDLE: begin
                    shift_nxt   = '0;
                    bit_cnt_nxt = '0;
                end
                DATA: begin
                    shift_nxt   = {rx_bit, shift[7:1]};
                    bit_cnt_nxt = bit_cnt + 1'b1;
                end
                PARITY: par_nxt = rx_bit;
                STOP: begin
                    if (!rx_bit) begin
                        ferr_nxt = 1'b1;
                    end else if (^{shift, par_bit}) begin
                        rx_en_nxt   = 1'b1;
                        rx_data_nxt = shift;
                    end else begin
                        perr_nxt = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            shift   <= '0;
            bit_cnt <= '0;
            par_bit <= 1'b0;
            tmo_cnt <= '0;
            rx_data <= '0;
            rx_en   <= 1'b0;
            perr    <= 1'b0;
            ferr    <= 1'b0;
        end else begin
            shift   <= shift_nxt;
            bit_cnt <= bit_cnt_nxt;
            par_bit <= par_nxt;
            tmo_cnt <= tmo_nxt;
            rx_data <= rx_data_nxt;
            rx_en   <= rx_en_nxt;
            perr    <= perr_nxt;
            ferr    <= ferr_nxt;
        end
    end

    // Prefix flags accumulate until a non-prefix byte or any receive error
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            pend_ext    <= 1'b0;
            pend_rel    <= 1'b0;
            key_code_q  <= '0;
            key_ext_q   <= 1'b0;
            key_rel_q   <= 1'b0;
            key_valid_q <= 1'b0;
        end else begin
            key_valid_q <= 1'b0;
            if (rx_en) begin
                if (rx_data == 8'hE0) begin
                    pend_ext <= 1'b1;
                end else if (rx_data == 8'hF0) begin
                    pend_rel <= 1'b1;
                end else begin
                    key_code_q  <= rx_data;
                    key_ext_q   <= pend_ext;
                    key_rel_q   <= pend_rel;
                    key_valid_q <= 1'b1;
                    pend_ext    <= 1'b0;
                    pend_rel    <= 1'b0;
                end
            end else if (perr || ferr) begin
                pend_ext <= 1'b0;
                pend_rel <= 1'b0;
            end
        end
    end

    assign ps2.received_data    = rx_data;
    assign ps2.received_data_en = rx_en;
    assign ps2.parity_error     = perr;
    assign ps2.frame_error      = ferr;
    assign ps2.key_code         = key_code_q;
    assign ps2.key_extended     = key_ext_q;
    assign ps2.key_release      = key_rel_q;
    assign ps2.key_valid        = key_valid_q;
endmodule
